// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters.
// Each grant sends one byte, waits for TxDone or a watchdog timeout, then holds TxEn low for a guard gap.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int GUARD_CYC   = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [N_REQ-1:0]          Req,
  input  logic [N_REQ*DATA_W-1:0]   ReqData,
  output logic [N_REQ-1:0]          Ack,
  output logic                      Err,
  output logic                      TxEn,
  output logic [DATA_W-1:0]         TxData,
  input  logic                      TxDone,
  output logic                      Busy,
  output logic [2:0]                GntId
);

  localparam int MAX_CYC = (TIMEOUT_CYC > GUARD_CYC) ? TIMEOUT_CYC : GUARD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, SEND, GUARD} stateT;

  stateT             state, nextState;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        rrPtr, nextPtr, pickId;
  logic              pickValid, txDoneOk, timedOut;
  logic [3:0]        scanIdx;
  logic [7:0]        reqExt;
  logic [N_REQ-1:0]  ackVec;
  logic [DATA_W-1:0] reqBytes [8];

  // Pad requests and bytes to eight slots so a 3-bit index always fits.
  assign reqExt = 8'(Req);

  for (genvar g = 0; g < 8; g++) begin : gBytes
    if (g < N_REQ) begin : gUsed
      assign reqBytes[g] = ReqData[g*DATA_W +: DATA_W];
    end else begin : gUnused
      assign reqBytes[g] = '0;
    end
  end

  // First requesting index at or after rrPtr, wrapping modulo N_REQ.
  always_comb begin
    pickValid = 1'b0;
    pickId    = '0;
    scanIdx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scanIdx = {1'b0, rrPtr} + 4'(i);
      if (scanIdx >= 4'(N_REQ)) scanIdx = scanIdx - 4'(N_REQ);
      if (!pickValid && reqExt[scanIdx[2:0]]) begin
        pickValid = 1'b1;
        pickId    = scanIdx[2:0];
      end
    end
  end

  always_comb begin
    ackVec = '0;
    for (int i = 0; i < N_REQ; i++) ackVec[i] = (GntId == 3'(i));
  end

  assign nextPtr = (GntId == 3'(N_REQ - 1)) ? 3'd0 : GntId + 3'd1;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= nextState;
  end

  // TxDone takes priority over the timeout on the final SEND cycle.
  always_comb begin
    nextState = state;
    txDoneOk  = 1'b0;
    timedOut  = 1'b0;
    TxEn      = 1'b0;
    Busy      = 1'b1;
    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (pickValid) nextState = SEND;
      end
      SEND: begin
        TxEn = 1'b1;
        if (TxDone) begin
          txDoneOk  = 1'b1;
          nextState = GUARD;
        end else if (cnt >= CNT_W'(TIMEOUT_CYC - 1)) begin
          timedOut  = 1'b1;
          nextState = GUARD;
        end
      end
      GUARD: begin
        if (cnt >= CNT_W'(GUARD_CYC - 1)) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // One counter serves as watchdog in SEND and gap timer in GUARD; it saturates.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt    <= '0;
      rrPtr  <= '0;
      TxData <= '0;
      GntId  <= '0;
      Ack    <= '0;
      Err    <= 1'b0;
    end else begin
      Ack <= '0;
      Err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pickValid) begin
            TxData <= reqBytes[pickId];
            GntId  <= pickId;
          end
        end
        SEND: begin
          if (txDoneOk || timedOut) begin
            cnt   <= '0;
            Ack   <= ackVec;
            Err   <= timedOut;
            rrPtr <= nextPtr;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued as requests are driven
// and retired by a monitor whenever the DUT pulses Ack.
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 8;
  localparam int GUARD   = 16;
  localparam int TIMEOUT = 50;

  typedef struct {
    logic [3:0] ack;
    logic [7:0] data;
    logic [2:0] id;
    logic       err;
  } expT;

  logic                     Clk = 1'b0;
  logic                     Rst = 1'b1;
  logic [N_REQ-1:0]         Req = '0;
  logic [N_REQ*DATA_W-1:0]  ReqData = '0;
  logic [N_REQ-1:0]         Ack;
  logic                     Err;
  logic                     TxEn;
  logic [DATA_W-1:0]        TxData;
  logic                     TxDone = 1'b0;
  logic                     Busy;
  logic [2:0]               GntId;

  expT expQ[$];
  expT popped;
  int  checkCount = 0;
  int  passCount  = 0;

  uart_tx_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .GUARD_CYC(GUARD), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .ReqData(ReqData), .Ack(Ack), .Err(Err),
    .TxEn(TxEn), .TxData(TxData), .TxDone(TxDone), .Busy(Busy), .GntId(GntId)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    else
      passCount++;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic void expectAck(input int id, input logic [7:0] data, input logic err);
    expT e;
    e.ack  = 4'(1 << id);
    e.data = data;
    e.id   = 3'(id);
    e.err  = err;
    expQ.push_back(e);
  endfunction

  task automatic waitTxEn();
    int w = 0;
    while (TxEn !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    checkOutput("txEnRise", 32'(TxEn), 1);
  endtask

  // Transmitter model: TxDone sampled on the delay-th edge after TxEn rose.
  task automatic finishFrame(input int delay);
    repeat (delay - 1) tick();
    TxDone = 1'b1;
    tick();
    TxDone = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] reqVal);
    Req = reqVal;
  endtask

  // Monitor: every Ack or Err pulse must match the oldest expected grant.
  always @(negedge Clk) begin
    if (!Rst && (Ack !== '0 || Err !== 1'b0)) begin
      if (expQ.size() == 0) begin
        checkOutput("ackUnexpected", 32'(Ack), 0);
        checkOutput("errUnexpected", 32'(Err), 0);
      end else begin
        popped = expQ.pop_front();
        checkOutput("ackBit", 32'(Ack), 32'(popped.ack));
        checkOutput("ackData", 32'(TxData), 32'(popped.data));
        checkOutput("ackGnt", 32'(GntId), 32'(popped.id));
        checkOutput("ackErr", 32'(Err), 32'(popped.err));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL globalTimeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int n;
    tick();
    tick();
    checkOutput("rstTxEn", 32'(TxEn), 0);
    checkOutput("rstBusy", 32'(Busy), 0);
    checkOutput("rstAck", 32'(Ack), 0);
    checkOutput("rstErr", 32'(Err), 0);
    checkOutput("rstTxData", 32'(TxData), 0);
    checkOutput("rstGntId", 32'(GntId), 0);
    Rst = 1'b0;
    tick();

    // Single request from requester 2
    ReqData[2*8 +: 8] = 8'hA5;
    applyStimulus(4'b0100);
    expectAck(2, 8'hA5, 1'b0);
    tick();
    checkOutput("t1TxEn", 32'(TxEn), 1);
    checkOutput("t1Busy", 32'(Busy), 1);
    checkOutput("t1TxData", 32'(TxData), 32'hA5);
    checkOutput("t1GntId", 32'(GntId), 2);
    finishFrame(3);
    checkOutput("t1AckNext", 32'(Ack), 32'b0100);
    checkOutput("t1ErrNext", 32'(Err), 0);
    applyStimulus(4'b0000);
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      if (TxEn !== 1'b0) checkOutput("t1GuardTxEn", 32'(TxEn), 0);
      n++;
      tick();
    end
    checkOutput("t1GuardLen", 32'(n), GUARD);

    // All four held: round-robin from pointer 0 after reset
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    ReqData = {8'h13, 8'h12, 8'h11, 8'h10};
    applyStimulus(4'b1111);
    expectAck(0, 8'h10, 1'b0);
    expectAck(1, 8'h11, 1'b0);
    expectAck(2, 8'h12, 1'b0);
    expectAck(3, 8'h13, 1'b0);
    expectAck(0, 8'h10, 1'b0);
    for (int k = 0; k < 5; k++) begin
      waitTxEn();
      if (k == 4) applyStimulus(4'b0000);
      finishFrame(20);
    end

    // Grant 2 leaves pointer at 3; then 1001 serves 3 before wrapping to 0
    applyStimulus(4'b0100);
    expectAck(2, 8'h12, 1'b0);
    waitTxEn();
    finishFrame(5);
    applyStimulus(4'b1001);
    expectAck(3, 8'h13, 1'b0);
    expectAck(0, 8'h10, 1'b0);
    waitTxEn();
    checkOutput("t3FirstGnt", 32'(GntId), 3);
    finishFrame(5);
    applyStimulus(4'b0001);
    waitTxEn();
    checkOutput("t3WrapGnt", 32'(GntId), 0);
    finishFrame(5);
    applyStimulus(4'b0000);

    // Watchdog abort, then TxDone on the final cycle counts as success
    ReqData[1*8 +: 8] = 8'h5A;
    applyStimulus(4'b0010);
    expectAck(1, 8'h5A, 1'b1);
    waitTxEn();
    n = 0;
    while (TxEn === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    checkOutput("t4SendLen", 32'(n), TIMEOUT);
    checkOutput("t4ErrPulse", 32'(Err), 1);
    checkOutput("t4GuardBusy", 32'(Busy), 1);
    applyStimulus(4'b0000);
    ReqData[1*8 +: 8] = 8'h5B;
    applyStimulus(4'b0010);
    expectAck(1, 8'h5B, 1'b0);
    waitTxEn();
    finishFrame(TIMEOUT);
    applyStimulus(4'b0000);

    // Asynchronous reset mid-SEND, then arbitration restarts from pointer 0
    applyStimulus(4'b0100);
    waitTxEn();
    tick();
    tick();
    #2 Rst = 1'b1;
    #1;
    checkOutput("t5RstTxEn", 32'(TxEn), 0);
    checkOutput("t5RstBusy", 32'(Busy), 0);
    checkOutput("t5RstAck", 32'(Ack), 0);
    applyStimulus(4'b0000);
    tick();
    Rst = 1'b0;
    applyStimulus(4'b1010);
    expectAck(1, 8'h5B, 1'b0);
    waitTxEn();
    checkOutput("t5GntAfterRst", 32'(GntId), 1);
    finishFrame(10);
    applyStimulus(4'b0000);

    // Spurious TxDone in GUARD and IDLE is ignored
    TxDone = 1'b1;
    tick();
    TxDone = 1'b0;
    checkOutput("t6GuardBusy", 32'(Busy), 1);
    checkOutput("t6GuardTxEn", 32'(TxEn), 0);
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checkOutput("t6Idle", 32'(Busy), 0);
    TxDone = 1'b1;
    tick();
    TxDone = 1'b0;
    checkOutput("t6IdleBusy", 32'(Busy), 0);
    tick();
    checkOutput("t6IdleAck", 32'(Ack), 0);

    // Requester 0 withdraws mid-SEND; its byte still completes
    ReqData[0 +: 8] = 8'h77;
    applyStimulus(4'b0001);
    expectAck(0, 8'h77, 1'b0);
    waitTxEn();
    tick();
    applyStimulus(4'b0000);
    finishFrame(8);
    repeat (GUARD + 4) tick();
    checkOutput("sbEmpty", 32'(expQ.size()), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
